// File: rtl/lsu_pkg.sv
// Shared definitions for the load/store unit: RV32I width codes
// and the FSM state encoding.
package lsu_pkg;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_READ  = 2'd1,
    ST_WRITE = 2'd2,
    ST_RESP  = 2'd3
  } lsu_state_e;

  function automatic logic f3_known(input logic [2:0] f3);
    logic ok;
    ok = 1'b0;
    case (f3)
      F3_B, F3_H, F3_W, F3_BU, F3_HU: ok = 1'b1;
      default: ok = 1'b0;
    endcase
    return ok;
  endfunction

endpackage

// File: rtl/lsu_lane_align.sv
// Byte/half lane handling: load extract + extend, store merge into
// the word read back from memory.
module lsu_lane_align
  import lsu_pkg::*;
(
  input  logic [2:0]  funct3_i,
  input  logic [1:0]  off_i,
  input  logic [31:0] rword_i,
  input  logic [31:0] wdata_i,
  output logic [31:0] load_o,
  output logic [31:0] store_o
);

  logic [7:0]  byte_v;
  logic [15:0] half_v;

  // Halfwords only look at off_i[1]; odd offsets are either
  // trapped upstream or silently rounded down.
  always_comb begin
    byte_v  = rword_i[{off_i, 3'b000} +: 8];
    half_v  = off_i[1] ? rword_i[31:16] : rword_i[15:0];
    load_o  = rword_i;
    store_o = rword_i;
    case (funct3_i)
      F3_B:    load_o = {{24{byte_v[7]}}, byte_v};
      F3_BU:   load_o = {24'h0, byte_v};
      F3_H:    load_o = {{16{half_v[15]}}, half_v};
      F3_HU:   load_o = {16'h0, half_v};
      default: load_o = rword_i;
    endcase
    case (funct3_i)
      F3_B: store_o[{off_i, 3'b000} +: 8] = wdata_i[7:0];
      F3_H: begin
        if (off_i[1]) store_o[31:16] = wdata_i[15:0];
        else          store_o[15:0]  = wdata_i[15:0];
      end
      default: store_o = wdata_i;
    endcase
  end

endmodule

// File: rtl/load_store_unit.sv
// RV32I load/store unit with read-modify-write sub-word stores.
// Define LSU_MISALIGN_TRAP_EN to trap misaligned H/W accesses.
module load_store_unit
  import lsu_pkg::*;
#(
  parameter int ADDR_WIDTH = 32
) (
  input  logic                  clock,
  input  logic                  reset_n,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic                  req_write,
  input  logic [2:0]            req_funct3,
  input  logic [ADDR_WIDTH-1:0] req_addr,
  input  logic [31:0]           req_wdata,
  output logic                  resp_valid,
  output logic [31:0]           resp_rdata,
  output logic                  resp_err,
  output logic [ADDR_WIDTH-1:0] address,
  output logic [31:0]           writeData,
  output logic                  writeEnable,
  output logic                  readEnable,
  input  logic [31:0]           readData
);

  lsu_state_e state_q, state_d;

  logic [2:0]            f3_q;
  logic [ADDR_WIDTH-1:0] addr_q;
  logic [31:0]           wdata_q;
  logic                  write_q;
  logic                  err_q;
  logic [31:0]           word_q;

  logic        hs;
  logic        req_err;
  logic [31:0] load_v;
  logic [31:0] store_v;

  assign hs = req_valid & req_ready;

  always_comb begin
    req_err = ~f3_known(req_funct3);
    if (req_write && req_funct3[2]) req_err = 1'b1;
`ifdef LSU_MISALIGN_TRAP_EN
    if (req_funct3[1:0] == 2'b01 && req_addr[0])
      req_err = 1'b1;
    if (req_funct3 == F3_W && req_addr[1:0] != 2'b00)
      req_err = 1'b1;
`endif
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) state_q <= ST_IDLE;
    else          state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE: begin
        if (hs) begin
          if (req_err)
            state_d = ST_RESP;
          else if (req_write && req_funct3 == F3_W)
            state_d = ST_WRITE;
          else
            state_d = ST_READ;
        end
      end
      ST_READ:  state_d = write_q ? ST_WRITE : ST_RESP;
      ST_WRITE: state_d = ST_RESP;
      ST_RESP:  state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      f3_q    <= '0;
      addr_q  <= '0;
      wdata_q <= '0;
      write_q <= 1'b0;
      err_q   <= 1'b0;
      word_q  <= '0;
    end else begin
      if (hs) begin
        f3_q    <= req_funct3;
        addr_q  <= req_addr;
        wdata_q <= req_wdata;
        write_q <= req_write;
        err_q   <= req_err;
      end
      if (state_q == ST_READ) word_q <= readData;
    end
  end

  lsu_lane_align u_align (
    .funct3_i (f3_q),
    .off_i    (addr_q[1:0]),
    .rword_i  (word_q),
    .wdata_i  (wdata_q),
    .load_o   (load_v),
    .store_o  (store_v)
  );

  always_comb begin
    req_ready   = reset_n && state_q == ST_IDLE;
    readEnable  = state_q == ST_READ;
    writeEnable = state_q == ST_WRITE;
    resp_valid  = state_q == ST_RESP;
    resp_err    = resp_valid && err_q;
    address     = {addr_q[ADDR_WIDTH-1:2], 2'b00};
    writeData   = writeEnable ? store_v : 32'h0;
    resp_rdata  = 32'h0;
    if (resp_valid && !err_q && !write_q)
      resp_rdata = load_v;
  end

endmodule

// File: tb/tb_load_store_unit.sv
// Self-checking bench for load_store_unit: directed vectors, a
// word-level memory model and a per-cycle compare process.
module tb_load_store_unit;

  logic        clock = 1'b0;
  logic        reset_n = 1'b0;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic        req_write = 1'b0;
  logic [2:0]  req_funct3 = 3'b0;
  logic [31:0] req_addr = 32'h0;
  logic [31:0] req_wdata = 32'h0;
  logic        resp_valid;
  logic [31:0] resp_rdata;
  logic        resp_err;
  logic [31:0] address;
  logic [31:0] writeData;
  logic        writeEnable;
  logic        readEnable;
  logic [31:0] readData;

  load_store_unit #(.ADDR_WIDTH(32)) dut (
    .clock       (clock),
    .reset_n     (reset_n),
    .req_valid   (req_valid),
    .req_ready   (req_ready),
    .req_write   (req_write),
    .req_funct3  (req_funct3),
    .req_addr    (req_addr),
    .req_wdata   (req_wdata),
    .resp_valid  (resp_valid),
    .resp_rdata  (resp_rdata),
    .resp_err    (resp_err),
    .address     (address),
    .writeData   (writeData),
    .writeEnable (writeEnable),
    .readEnable  (readEnable),
    .readData    (readData)
  );

  always #5 clock = ~clock;

  int cyc = 0;
  always @(posedge clock) cyc <= cyc + 1;

  // DataMemory stand-in
  logic [31:0] mem [16] = '{0: 32'h12345678, 1: 32'hCAFEBABE,
                            2: 32'h87654321, default: 32'h0};
  always @(posedge clock)
    if (writeEnable) mem[address[5:2]] <= writeData;
  assign readData = readEnable ? mem[address[5:2]] : 32'h0;

  typedef struct {
    bit        w;
    bit [2:0]  f3;
    bit [31:0] a;
    bit [31:0] wd;
    bit        le;
    bit [31:0] ld;
    bit        lerr;
    int        llat;
    bit        lwe;
    bit [31:0] lwd;
    int        gap;
  } vec_t;

  function automatic vec_t mk(bit w, bit [2:0] f3, bit [31:0] a,
                              bit [31:0] wd, bit [31:0] ld,
                              bit lerr, int llat);
    vec_t v;
    v.w = w; v.f3 = f3; v.a = a; v.wd = wd;
    v.le = 1'b1; v.ld = ld; v.lerr = lerr; v.llat = llat;
    v.lwe = 1'b0; v.lwd = 32'h0; v.gap = 0;
    return v;
  endfunction

  // Reference model of the request semantics
  function automatic bit m_err(bit w, bit [2:0] f3, bit [31:0] a);
    if (f3 == 3 || f3 == 6 || f3 == 7) return 1'b1;
    if (w && f3 >= 4) return 1'b1;
`ifdef LSU_MISALIGN_TRAP_EN
    if ((f3 == 1 || f3 == 5) && (a % 2) != 0) return 1'b1;
    if (f3 == 2 && (a % 4) != 0) return 1'b1;
`endif
    return 1'b0;
  endfunction

  function automatic bit [31:0] m_load(bit [31:0] word, bit [2:0] f3,
                                       bit [31:0] a);
    int sh;
    bit [31:0] v;
    case (f3)
      0, 4: begin
        sh = 8 * int'(a % 4);
        v = (word >> sh) & 32'hFF;
        if (f3 == 0 && v >= 128) v = v | 32'hFFFFFF00;
      end
      1, 5: begin
        sh = 16 * int'((a / 2) % 2);
        v = (word >> sh) & 32'hFFFF;
        if (f3 == 1 && v >= 32768) v = v | 32'hFFFF0000;
      end
      default: v = word;
    endcase
    return v;
  endfunction

  function automatic bit [31:0] m_store(bit [31:0] word, bit [2:0] f3,
                                        bit [31:0] a, bit [31:0] wd);
    int sh;
    bit [31:0] mask;
    case (f3)
      0: begin
        sh = 8 * int'(a % 4);
        mask = 32'hFF << sh;
        return (word & ~mask) | ((wd & 32'hFF) << sh);
      end
      1: begin
        sh = 16 * int'((a / 2) % 2);
        mask = 32'hFFFF << sh;
        return (word & ~mask) | ((wd & 32'hFFFF) << sh);
      end
      default: return wd;
    endcase
  endfunction

  bit [31:0] ref_mem [16] = '{0: 32'h12345678, 1: 32'hCAFEBABE,
                              2: 32'h87654321, default: 32'h0};

  vec_t      cur;
  vec_t      pvec;
  bit        pv = 1'b0;
  int        p_hs, p_lat, p_rd, p_wr;
  bit [31:0] p_rdata, p_word;
  bit        p_err;
  int        last_resp = 0;
  bit        er, ew, eresp;
  int        checks = 0;
  int        errors = 0;

  task automatic chk(input string nm, input logic [31:0] got,
                     input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %h want %h cycle %0d", nm, got, exp, cyc);
    end
  endtask

  always @(negedge clock) begin
    if (!reset_n) begin
      chk("rst_req_ready", req_ready, 0);
      chk("rst_flags", {resp_valid, resp_err, readEnable, writeEnable}, 0);
      chk("rst_resp_rdata", resp_rdata, 0);
      chk("rst_address", address, 0);
      chk("rst_writeData", writeData, 0);
      pv = 1'b0;
    end else begin
      er    = pv && cyc == p_rd;
      ew    = pv && cyc == p_wr;
      eresp = pv && cyc == p_hs + p_lat;
      chk("req_ready", req_ready, !pv);
      chk("readEnable", readEnable, er);
      chk("writeEnable", writeEnable, ew);
      if (er || ew) chk("address", address, pvec.a & ~32'h3);
      if (ew) begin
        chk("writeData", writeData, p_word);
        if (pvec.lwe) chk("lit_writeData", writeData, pvec.lwd);
      end
      chk("resp_valid", resp_valid, eresp);
      if (eresp) begin
        chk("resp_rdata", resp_rdata, p_rdata);
        chk("resp_err", resp_err, p_err);
        if (pvec.le) begin
          chk("lit_rdata", resp_rdata, pvec.ld);
          chk("lit_err", resp_err, pvec.lerr);
          chk("lit_latency", cyc - p_hs, pvec.llat);
        end
        if (pvec.gap != 0) chk("resp_gap", cyc - last_resp, pvec.gap);
        if (pvec.w && !p_err) ref_mem[pvec.a[5:2]] = p_word;
        last_resp = cyc;
        pv = 1'b0;
      end
      if (req_valid && req_ready) begin
        pvec    = cur;
        p_hs    = cyc;
        p_err   = m_err(cur.w, cur.f3, cur.a);
        p_rdata = (p_err || cur.w) ? 32'h0
                : m_load(ref_mem[cur.a[5:2]], cur.f3, cur.a);
        p_word  = m_store(ref_mem[cur.a[5:2]], cur.f3, cur.a, cur.wd);
        p_rd    = -1;
        p_wr    = -1;
        if (p_err) begin
          p_lat = 1;
        end else if (!cur.w) begin
          p_lat = 2; p_rd = cyc + 1;
        end else if (cur.f3 == 2) begin
          p_lat = 2; p_wr = cyc + 1;
        end else begin
          p_lat = 3; p_rd = cyc + 1; p_wr = cyc + 2;
        end
        pv = 1'b1;
      end
    end
  end

  task automatic drive(input vec_t v);
    cur        = v;
    req_write  = v.w;
    req_funct3 = v.f3;
    req_addr   = v.a;
    req_wdata  = v.wd;
    req_valid  = 1'b1;
  endtask

  task automatic wait_ready();
    int n = 0;
    @(negedge clock);
    while (!req_ready && n < 20) begin
      @(negedge clock);
      n++;
    end
    if (!req_ready) begin
      $display("FAIL handshake_timeout cycle %0d", cyc);
      $fatal(1, "no handshake");
    end
  endtask

  task automatic wait_idle();
    int n = 0;
    @(negedge clock); #2;
    while (pv && n < 20) begin
      @(negedge clock); #2;
      n++;
    end
    if (pv) begin
      $display("FAIL response_timeout cycle %0d", cyc);
      $fatal(1, "no response");
    end
  endtask

  task automatic issue(input vec_t v);
    @(posedge clock); #1;
    drive(v);
    wait_ready();
    @(posedge clock); #1;
    req_valid = 1'b0;
    wait_idle();
  endtask

  vec_t v;

  initial begin
    repeat (3) @(negedge clock);
    #2 reset_n = 1'b1;

    issue(mk(0, 3'b000, 32'h1, 0, 32'h00000056, 0, 2));
    issue(mk(0, 3'b100, 32'h3, 0, 32'h00000012, 0, 2));
    issue(mk(0, 3'b001, 32'hA, 0, 32'hFFFF8765, 0, 2));
    issue(mk(0, 3'b101, 32'hA, 0, 32'h00008765, 0, 2));
    issue(mk(0, 3'b000, 32'hB, 0, 32'hFFFFFF87, 0, 2));
    issue(mk(0, 3'b010, 32'h4, 0, 32'hCAFEBABE, 0, 2));

    issue(mk(1, 3'b010, 32'h8, 32'h87654321, 32'h0, 0, 2));
    v = mk(1, 3'b000, 32'h9, 32'hAA, 32'h0, 0, 3);
    v.lwe = 1'b1; v.lwd = 32'h8765AA21;
    issue(v);
    issue(mk(0, 3'b010, 32'h8, 0, 32'h8765AA21, 0, 2));
    v = mk(1, 3'b001, 32'h2, 32'h1234BEEF, 32'h0, 0, 3);
    v.lwe = 1'b1; v.lwd = 32'hBEEF5678;
    issue(v);
    issue(mk(0, 3'b001, 32'h2, 0, 32'hFFFFBEEF, 0, 2));

    issue(mk(0, 3'b011, 32'h0, 0, 32'h0, 1, 1));
    issue(mk(0, 3'b110, 32'h4, 0, 32'h0, 1, 1));
    issue(mk(0, 3'b111, 32'h8, 0, 32'h0, 1, 1));
    issue(mk(1, 3'b100, 32'h8, 32'hFF, 32'h0, 1, 1));
    issue(mk(1, 3'b101, 32'h8, 32'hFF, 32'h0, 1, 1));

`ifdef LSU_MISALIGN_TRAP_EN
    issue(mk(0, 3'b010, 32'h6, 0, 32'h0, 1, 1));
    issue(mk(0, 3'b101, 32'h5, 0, 32'h0, 1, 1));
    issue(mk(1, 3'b010, 32'h9, 32'h11, 32'h0, 1, 1));
`else
    issue(mk(0, 3'b010, 32'h6, 0, 32'hCAFEBABE, 0, 2));
    issue(mk(0, 3'b101, 32'h5, 0, 32'h0000BABE, 0, 2));
    issue(mk(0, 3'b001, 32'h7, 0, 32'hFFFFCAFE, 0, 2));
`endif

    // Reset lands in the WRITE cycle of an SB; the merge must be lost
    v = mk(1, 3'b000, 32'h9, 32'h55, 32'h0, 0, 3);
    v.le = 1'b0;
    @(posedge clock); #1;
    drive(v);
    wait_ready();
    @(posedge clock); #1;
    req_valid = 1'b0;
    begin
      int n = 0;
      @(negedge clock);
      while (!writeEnable && n < 10) begin
        @(negedge clock);
        n++;
      end
    end
    #2 reset_n = 1'b0;
    @(negedge clock);
    #2 reset_n = 1'b1;
    issue(mk(0, 3'b010, 32'h8, 0, 32'h8765AA21, 0, 2));

    // Five loads with req_valid held continuously
    v = mk(0, 3'b010, 32'h0, 0, 32'hBEEF5678, 0, 2);
    @(posedge clock); #1;
    drive(v);
    for (int k = 0; k < 5; k++) begin
      wait_ready();
      @(posedge clock); #1;
      v.gap = 3;
      cur = v;
      if (k == 4) req_valid = 1'b0;
    end
    wait_idle();

    repeat (3) @(negedge clock);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
